// File: rtl/asconp_pkg.sv
// Shared constants and types for the Ascon-p permutation cores:
// S-box tables, linear-layer rotations, the round constant and FSM encoding.
package asconp_pkg;

  localparam int ROUNDS_MAX = 12;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_DONE = 2'd2
  } fsm_state_t;

  // Index 0 is x0, index 4 is x4.
  typedef logic [4:0][63:0] state_t;

  // Forward table includes both affine layers; column index is {x0,x1,x2,x3,x4}.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam logic [4:0] ISBOX [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  // n in 0..63; a zero rotation returns x unchanged.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << ((64 - n) % 64));
  endfunction

endpackage

// File: rtl/asconp_inv_round.sv
// One combinational inverse Ascon round: inverse linear layer, inverse
// S-box, then removal of the round constant for forward round rnd_i.
module asconp_inv_round
  import asconp_pkg::*;
(
  input  logic [3:0] rnd_i,
  input  state_t     state_i,
  output state_t     state_o
);

  state_t w_lin;
  state_t w_sub;

  // L = I + R^a + R^b has order 64, so chaining its squarings k=0..5 gives L^63 = L^-1.
  function automatic logic [63:0] inv_lin(input logic [63:0] y, input int a, input int b);
    logic [63:0] t;
    t = y;
    for (int k = 0; k < 6; k++) begin
      t = t ^ rotr(t, (a << k) % 64) ^ rotr(t, (b << k) % 64);
    end
    return t;
  endfunction

  always_comb begin
    logic [4:0] w_col;
    logic [4:0] w_inv;
    w_lin = '0;
    w_sub = '0;
    w_col = '0;
    w_inv = '0;
    for (int w = 0; w < 5; w++) begin
      w_lin[w] = inv_lin(state_i[w], ROT_A[w], ROT_B[w]);
    end
    for (int j = 0; j < 64; j++) begin
      w_col = {w_lin[0][j], w_lin[1][j], w_lin[2][j], w_lin[3][j], w_lin[4][j]};
      w_inv = ISBOX[w_col];
      for (int w = 0; w < 5; w++) begin
        w_sub[w][j] = w_inv[4-w];
      end
    end
  end

  assign state_o = {w_sub[4], w_sub[3], w_sub[2] ^ {56'd0, rc(rnd_i)}, w_sub[1], w_sub[0]};

endmodule

// File: rtl/asconp_inv.sv
// Sequential inverse Ascon permutation: accepts a permuted state, undoes
// nr_i rounds (one per clock, last forward round first) and returns it.
module asconp_inv
  import asconp_pkg::*;
#(
  parameter int MAXR = ROUNDS_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  nr_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o,
  output fsm_state_t  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in IDLE, out_valid only in DONE, so a job
  // is never accepted in the same cycle its predecessor is returned.

  localparam logic [3:0] NR_MAX   = 4'(MAXR);
  localparam logic [3:0] RND_LAST = 4'(ROUNDS_MAX - 1);

  fsm_state_t r_fsm;
  state_t     r_state;
  state_t     r_out;
  logic [3:0] r_rnd;
  logic [3:0] r_cnt;
  logic       r_in_ready;
  logic       r_out_valid;

  state_t     w_in;
  state_t     w_round;

  assign w_in = {x4_i, x3_i, x2_i, x1_i, x0_i};

  asconp_inv_round u_round (
    .rnd_i   (r_rnd),
    .state_i (r_state),
    .state_o (w_round)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= FSM_IDLE;
      r_state     <= '0;
      r_out       <= '0;
      r_rnd       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        FSM_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_state    <= w_in;
            r_rnd      <= RND_LAST;
            r_in_ready <= 1'b0;
            if (nr_i == 4'd0) begin
              r_cnt       <= '0;
              r_out       <= w_in;
              r_out_valid <= 1'b1;
              r_fsm       <= FSM_DONE;
            end else begin
              r_cnt <= (nr_i > NR_MAX) ? NR_MAX : nr_i;
              r_fsm <= FSM_RUN;
            end
          end
        end
        FSM_RUN: begin
          r_state <= w_round;
          r_cnt   <= r_cnt - 4'd1;
          // rnd stops at the first round so it never wraps below zero.
          if (r_cnt == 4'd1) begin
            r_out       <= w_round;
            r_out_valid <= 1'b1;
            r_fsm       <= FSM_DONE;
          end else begin
            r_rnd <= r_rnd - 4'd1;
          end
        end
        FSM_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= FSM_IDLE;
          end
        end
        default: r_fsm <= FSM_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign x0_o        = r_out[0];
  assign x1_o        = r_out[1];
  assign x2_o        = r_out[2];
  assign x3_o        = r_out[3];
  assign x4_o        = r_out[4];
  assign dbg_state_o = r_fsm;

endmodule
